// File: rtl/motor_encoder_multi.sv
// motor_encoder_multi: per-channel filtered 4x quadrature decode with index capture, error flags and windowed velocity
module motor_encoder_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int FILT_LEN   = 3,
    parameter int VEL_PERIOD = 100000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             enc_a,
    input  logic [NUM_CH-1:0]             enc_b,
    input  logic [NUM_CH-1:0]             enc_z,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic [NUM_CH-1:0]             cnt_clear,
    input  logic [NUM_CH-1:0]             idx_zero_en,
    input  logic [NUM_CH-1:0]             err_clear,
    output logic [NUM_CH*CNT_WIDTH-1:0]   position,
    output logic [NUM_CH*CNT_WIDTH-1:0]   idx_pos,
    output logic [NUM_CH*CNT_WIDTH-1:0]   velocity,
    output logic                          vel_valid,
    output logic [NUM_CH-1:0]             dir,
    output logic [NUM_CH-1:0]             err
);
    localparam int NS = 3 * NUM_CH;
    localparam int WW = $clog2(VEL_PERIOD);
    localparam logic [WW-1:0] LAST = WW'(VEL_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [NS-1:0] s1, s2, filt;
    logic [NUM_CH-1:0] fa, fb, fz, pa, pb, pz;
    logic [WW-1:0] win;
    logic tc;

    assign tc = win == LAST;
    assign {fz, fb, fa} = filt;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            pa <= '0;
            pb <= '0;
            pz <= '0;
            win <= '0;
            vel_valid <= 1'b0;
        end else begin
            s1 <= {enc_z, enc_b, enc_a};
            s2 <= s1;
            pa <= fa;
            pb <= fb;
            pz <= fz;
            win <= tc ? '0 : win + WW'(1);
            vel_valid <= tc;
        end
    end

    // a filtered bit only follows the synchroniser after FILT_LEN consecutive differing cycles
    for (genvar i = 0; i < NS; i++) begin : g_filt
        logic [3:0] run;
        logic f;
        always_ff @(posedge clock) begin
            if (reset) begin
                run <= '0;
                f <= 1'b0;
            end else if (s2[i] == f) begin
                run <= '0;
            end else if (run == 4'(FILT_LEN - 1)) begin
                run <= '0;
                f <= s2[i];
            end else begin
                run <= run + 4'd1;
            end
        end
        assign filt[i] = f;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0] pc, pp, d;
        logic up, dn, bad, z_rise, dir_r, err_r;
        logic [CNT_WIDTH-1:0] pos, nxt, ipos, vel, snap;
        // phase index 0..3 along the up sequence 00->10->11->01
        assign pc = {fb[i], fa[i] ^ fb[i]};
        assign pp = {pb[i], pa[i] ^ pb[i]};
        assign d = pc - pp;
        assign up = ch_enable[i] && d == 2'd1;
        assign dn = ch_enable[i] && d == 2'd3;
        assign bad = ch_enable[i] && d == 2'd2;
        assign z_rise = fz[i] && !pz[i];
        assign nxt = up ? pos + ONE : dn ? pos - ONE : pos;
        always_ff @(posedge clock) begin
            if (reset) begin
                pos <= '0;
                ipos <= '0;
                vel <= '0;
                snap <= '0;
                dir_r <= 1'b0;
                err_r <= 1'b0;
            end else begin
                pos <= (cnt_clear[i] || (idx_zero_en[i] && z_rise)) ? '0 : nxt;
                if (z_rise) ipos <= nxt;
                if (up || dn) dir_r <= up;
                err_r <= bad || (err_r && !err_clear[i]);
                if (tc) begin
                    vel <= pos - snap;
                    snap <= pos;
                end
            end
        end
        assign position[i*CNT_WIDTH +: CNT_WIDTH] = pos;
        assign idx_pos[i*CNT_WIDTH +: CNT_WIDTH] = ipos;
        assign velocity[i*CNT_WIDTH +: CNT_WIDTH] = vel;
        assign dir[i] = dir_r;
        assign err[i] = err_r;
    end
endmodule

// File: tb/tb_motor_encoder_multi.sv
// tb_motor_encoder_multi: randomized scoreboard bench against a behavioural encoder model
module tb_motor_encoder_multi;
    localparam int NC = 4;
    localparam int W = 8;
    localparam int VP = 1000;

    logic clock = 1'b0;
    logic reset;
    logic [NC-1:0] enc_a, enc_b, enc_z, ch_enable, cnt_clear, idx_zero_en, err_clear;
    logic [NC*W-1:0] position, idx_pos, velocity;
    logic vel_valid;
    logic [NC-1:0] dir, err;

    motor_encoder_multi #(.NUM_CH(NC), .CNT_WIDTH(W), .FILT_LEN(3), .VEL_PERIOD(VP)) dut (
        .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .ch_enable(ch_enable), .cnt_clear(cnt_clear), .idx_zero_en(idx_zero_en),
        .err_clear(err_clear), .position(position), .idx_pos(idx_pos), .velocity(velocity),
        .vel_valid(vel_valid), .dir(dir), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NC-1:0][W-1:0] pos;
        logic [NC-1:0][W-1:0] vel;
        logic [NC-1:0] dir;
        logic [NC-1:0] err;
    } exp_t;

    exp_t q[$];
    int errors = 0, checks = 0, cyc = 0;
    int mpos[NC], msnap[NC];
    bit mdir[NC], merr[NC];
    logic [1:0] ab[NC];

    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] dpos(input int c);
        return position[c*W +: W];
    endfunction

    function automatic logic [W-1:0] didx(input int c);
        return idx_pos[c*W +: W];
    endfunction

    function automatic logic [1:0] next_ab(input logic [1:0] cur, input bit up);
        case (cur)
            2'b00: return up ? 2'b10 : 2'b01;
            2'b10: return up ? 2'b11 : 2'b00;
            2'b11: return up ? 2'b01 : 2'b10;
            default: return up ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic step(input int c, input bit up, input int hold);
        ab[c] = next_ab(ab[c], up);
        enc_a[c] = ab[c][1];
        enc_b[c] = ab[c][0];
        if (ch_enable[c]) begin
            mpos[c] = (mpos[c] + (up ? 1 : 255)) % 256;
            mdir[c] = up;
        end
        tick(hold);
    endtask

    task automatic illegal(input int c);
        ab[c] = ab[c] ^ 2'b11;
        enc_a[c] = ab[c][1];
        enc_b[c] = ab[c][0];
        if (ch_enable[c]) merr[c] = 1'b1;
        tick(10);
    endtask

    task automatic end_window(input int k);
        exp_t e;
        while (cyc < VP * (k + 1) - 50) tick(1);
        for (int c = 0; c < NC; c++) begin
            e.pos[c] = W'(mpos[c]);
            e.vel[c] = W'((mpos[c] - msnap[c] + 256) % 256);
            e.dir[c] = mdir[c];
            e.err[c] = merr[c];
            msnap[c] = mpos[c];
        end
        q.push_back(e);
        while (cyc < VP * (k + 1) + 10) tick(1);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (vel_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vel_valid_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("vel_valid_cycle", cyc % VP, 0);
                for (int c = 0; c < NC; c++) begin
                    chk($sformatf("velocity[%0d]", c), velocity[c*W +: W], e.vel[c]);
                    chk($sformatf("win_position[%0d]", c), dpos(c), e.pos[c]);
                    chk($sformatf("win_dir[%0d]", c), dir[c], e.dir[c]);
                    chk($sformatf("win_err[%0d]", c), err[c], e.err[c]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $finish;
    end

    initial begin
        reset = 1'b1;
        {enc_a, enc_b, enc_z, cnt_clear, idx_zero_en, err_clear} = '0;
        ch_enable = '1;
        for (int c = 0; c < NC; c++) begin
            mpos[c] = 0; msnap[c] = 0; mdir[c] = 0; merr[c] = 0; ab[c] = 2'b00;
        end
        tick(3);
        chk("reset_position", position, 0);
        chk("reset_idx_pos", idx_pos, 0);
        chk("reset_velocity", velocity, 0);
        chk("reset_flags", {vel_valid, dir, err}, 0);
        reset = 1'b0;

        // window 0: latency, forward count, reverse wrap, illegal/err_clear, glitch, ch3 +25
        step(0, 1, 5);
        chk("latency_edge5", dpos(0), 0);
        tick(1);
        chk("latency_edge6", dpos(0), 1);
        tick(4);
        for (int n = 0; n < 15; n++) step(0, 1, 10);
        chk("fwd16_position", dpos(0), 16);
        chk("fwd16_dir", dir[0], 1);
        chk("fwd16_others", position[NC*W-1:W], 0);
        for (int n = 0; n < 3; n++) step(1, 0, 10);
        chk("rev3_position", dpos(1), 8'hFD);
        chk("rev3_dir", dir[1], 0);
        for (int n = 0; n < 3; n++) step(1, 1, 10);
        chk("fwd3_position", dpos(1), 0);
        illegal(2);
        chk("illegal_err", err[2], 1);
        chk("illegal_position", dpos(2), 0);
        err_clear[2] = 1'b1;
        tick(1);
        err_clear[2] = 1'b0;
        tick(2);
        merr[2] = 1'b0;
        chk("err_clear", err[2], 0);
        enc_a[2] = ~enc_a[2];
        tick(2);
        enc_a[2] = ~enc_a[2];
        tick(10);
        chk("glitch_position", dpos(2), 0);
        chk("glitch_err", err[2], 0);
        for (int n = 0; n < 25; n++) step(3, 1, 10);
        end_window(0);

        // window 1: ch3 -10, index zero, cnt_clear priority, disabled channel
        for (int n = 0; n < 10; n++) step(3, 0, 10);
        for (int n = 0; n < 24; n++) step(0, 1, 10);
        chk("pre_index_position", dpos(0), 40);
        idx_zero_en[0] = 1'b1;
        enc_z[0] = 1'b1;
        step(0, 1, 6);
        mpos[0] = 0;
        chk("idx_zero_idx_pos", didx(0), 41);
        chk("idx_zero_position", dpos(0), 0);
        tick(4);
        enc_z[0] = 1'b0;
        idx_zero_en[0] = 1'b0;
        tick(10);
        for (int n = 0; n < 5; n++) step(0, 1, 10);
        enc_z[0] = 1'b1;
        step(0, 1, 5);
        cnt_clear[0] = 1'b1;
        tick(1);
        cnt_clear[0] = 1'b0;
        mpos[0] = 0;
        chk("clear_position", dpos(0), 0);
        chk("capture_idx_pos", didx(0), 6);
        tick(4);
        enc_z[0] = 1'b0;
        tick(10);
        ch_enable[1] = 1'b0;
        for (int n = 0; n < 5; n++) step(1, 1, 10);
        chk("disabled_position", dpos(1), W'(mpos[1]));
        ch_enable[1] = 1'b1;
        tick(10);
        chk("reenable_position", dpos(1), W'(mpos[1]));
        end_window(1);

        // windows 2..4: random steps, illegal jumps and enable toggles
        for (int k = 2; k < 5; k++) begin
            for (int n = 0; n < 40; n++) begin
                int c, a;
                c = $urandom_range(0, NC - 1);
                a = $urandom_range(0, 9);
                if (a == 0) illegal(c);
                else if (a == 1) begin
                    ch_enable[c] = ~ch_enable[c];
                    tick(10);
                end else step(c, a > 5, 10);
            end
            end_window(k);
        end
        chk("scoreboard_drained", q.size(), 0);

        ch_enable = '1;
        step(0, 1, 3);
        step(3, 0, 2);
        reset = 1'b1;
        tick(1);
        chk("midreset_position", position, 0);
        chk("midreset_idx_pos", idx_pos, 0);
        chk("midreset_velocity", velocity, 0);
        chk("midreset_flags", {vel_valid, dir, err}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
